ps2_keymatrix: RTL and testbench
================================

# ps2_keymatrix

PS/2 keyboard front end that emulates the 8×5 Spectrum key matrix and drives the ULA keyboard inputs `kd[4:0]`. It receives PS/2 scan-code set 2 frames and decodes make, break, E0 and F0 sequences into a 40-bit pressed-key matrix. It answers the ULA's port #FE reads combinationally from CPU address lines A15..A8. The block sits directly upstream of the ULA `kd` input, replacing the physical membrane.

## Interface

Parameters:
- `FILTER_LEN`, default 8: consecutive equal samples required to accept a new `ps2_clk` level.
- `TIMEOUT`, default 2047: idle clk14 cycles (about 146 µs) without a PS/2 falling edge before the frame receiver resets.

Ports:
- `clk14`  in  1  system clock, 14 MHz.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ps2_clk`  in  1  PS/2 clock, asynchronous, open-drain (pulled up externally).
- `ps2_dat`  in  1  PS/2 data, asynchronous.
- `addr_hi`  in  8  CPU A15..A8; `addr_hi[r]`=0 selects matrix row r.
- `kd`  out  5  key columns, active-low; 1 = not pressed.
- `frame_err`  out  1  one-cycle pulse on a parity, start or stop error.

## Operation

- **Input conditioning.** `ps2_clk` and `ps2_dat` each pass through a 2-FF synchroniser. `ps2_clk` then passes a `FILTER_LEN` glitch filter. A falling edge of the filtered clock produces a one-cycle `fall` strobe.
- **Frame receiver.** An 11-bit frame is sampled on `fall`: start=0, 8 data bits LSB first, odd parity, stop=1. A 4-bit counter runs 0..10.
  - The frame is accepted only if start=0, data+parity has odd weight, and stop=1. Otherwise `frame_err` pulses and the byte is dropped.
  - The idle counter resets on every `fall`. When it reaches `TIMEOUT`, the bit counter returns to 0 and any partial frame is discarded without `frame_err`.
- **Decoder state machine.** States are IDLE, EXT (E0 seen), BRK (F0 seen) and EXTBRK (E0 F0 seen).
  - Byte E0: IDLE→EXT.
  - Byte F0: IDLE→BRK, EXT→EXTBRK.
  - Any other byte: apply it as make (IDLE/EXT) or break (BRK/EXTBRK) with the ext flag set in EXT/EXTBRK, then return to IDLE.
  - Byte AA (BAT), 00 or FF (overrun) in any state: clear the whole matrix and go to IDLE.
  - Unmapped codes: no matrix change, return to IDLE.
- **Matrix.** 40 flops, `m[row][col]`; col0 is the outermost key. A make sets all mapped bits; a break clears them.
  - row0: CS(12, 59) Z(1A) X(22) C(21) V(2A)
  - row1: A(1C) S(1B) D(23) F(2B) G(34)
  - row2: Q(15) W(1D) E(24) R(2D) T(2C)
  - row3: 1(16) 2(1E) 3(26) 4(25) 5(2E)
  - row4: 0(45) 9(46) 8(3E) 7(3D) 6(36)
  - row5: P(4D) O(44) I(43) U(3C) Y(35)
  - row6: Enter(5A) L(4B) K(42) J(3B) H(33)
  - row7: Space(29) SS(14, E0 14) M(3A) N(31) B(32)
- **Compound keys.** Each sets or clears two bits:
  - Backspace 66 = CS+0
  - E0 6B (left) = CS+5
  - E0 72 (down) = CS+6
  - E0 75 (up) = CS+7
  - E0 74 (right) = CS+8
- **Shared bits.** Bits set by compound keys and plain keys are shared; a break clears a bit even if another held key also maps to it. This is accepted behaviour.
- **Output.** `kd[c] = ~OR over r of (m[r][c] & ~addr_hi[r])`. `kd` is purely combinational from `m` and `addr_hi`, with no clk14 delay, so the ULA port read sees it within the same IORQ cycle.
- **Reset.** All outputs and state return to their reset values: matrix all 0, decoder IDLE, bit counter 0, idle counter 0, filter state 1, `kd`=5'b11111, `frame_err`=0.

## Timing

- Sync plus filter delay from a pin edge to `fall` is 2+`FILTER_LEN` cycles.
- The stop bit is sampled on the `fall` at cycle N. The byte is valid and the decoder state updates at N+1. The matrix bit changes at N+2. `kd` follows the matrix in the same cycle.
- `frame_err` is high at N+1 only.
- Reset asserted mid-frame aborts the frame immediately and asynchronously. The first frame after release is received normally.
- A timeout in EXT or BRK does not reset the decoder; only AA, 00 or FF do.

## Test plan

- **Make and column read.** Send make 1C (A) with `addr_hi`=FD → `kd`=11110. With `addr_hi`=FE → `kd`=11111.
- **Break and row OR.** Send makes 12 and 1A, then `addr_hi`=00 → `kd`=11100. Send F0 12 → `kd`=11101.
- **Extended compound key.** Send E0 75 → row0 (`addr_hi`=FE) `kd`=11110 and row4 (`addr_hi`=EF) `kd`=10111. Send E0 F0 75 → both read 11111.
- **Parity error.** Send 1C with even parity → `frame_err` pulses once and `kd` stays 11111 for all rows. The next good frame 1C is accepted.
- **Timeout recovery.** Send 5 bits, wait 3000 cycles, then a full 29 frame → Space pressed (`addr_hi`=7F gives `kd`=11110) and no `frame_err`.
- **Matrix clear and reset.** Hold several keys, send AA → all rows 11111. Separately, assert `rst_n` low mid-frame → `kd`=11111 and the decoder is in IDLE.

Source files
------------

// File: rtl/ps2_keymatrix.sv
// PS/2 set-2 keyboard front end emulating the 8x5 Spectrum key matrix.
// Decoded make/break codes drive a 40-bit matrix read combinationally through kd.
module ps2_keymatrix #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 2047
) (
  input  logic       clk14,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  input  logic [7:0] addr_hi,
  output logic [4:0] kd,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int IW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXTBRK} state_e;

  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          filt_q, fall_q;
  logic [FW-1:0] flt_cnt_q;
  logic [IW-1:0] idle_q;
  logic [3:0]    bit_cnt_q;
  logic [9:0]    sr_q;
  logic [7:0]    byte_q;
  logic          byte_vld_q, frame_err_q;
  state_e        state_q, state_d;
  logic [39:0]   m_q, m_d;
  logic          flt_done;

  assign flt_done  = (clk_s2_q != filt_q) && (flt_cnt_q == FW'(FILTER_LEN - 1));
  assign frame_err = frame_err_q;

  always_ff @(posedge clk14 or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      dat_s1_q  <= 1'b1;
      dat_s2_q  <= 1'b1;
      filt_q    <= 1'b1;
      flt_cnt_q <= '0;
      fall_q    <= 1'b0;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_dat;
      dat_s2_q <= dat_s1_q;
      fall_q   <= flt_done && filt_q;
      if (clk_s2_q == filt_q) begin
        flt_cnt_q <= '0;
      end else if (flt_done) begin
        filt_q    <= clk_s2_q;
        flt_cnt_q <= '0;
      end else begin
        flt_cnt_q <= flt_cnt_q + 1'b1;
      end
    end
  end

  // Frame layout after ten shifts: sr_q[0]=start, [8:1]=data, [9]=parity; stop is the live sample.
  always_ff @(posedge clk14 or negedge rst_n) begin
    if (!rst_n) begin
      idle_q      <= '0;
      bit_cnt_q   <= '0;
      sr_q        <= '0;
      byte_q      <= '0;
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
      if (fall_q) begin
        idle_q <= '0;
        if (bit_cnt_q == 4'd10) begin
          bit_cnt_q <= '0;
          if (!sr_q[0] && ^sr_q[9:1] && dat_s2_q) begin
            byte_q     <= sr_q[8:1];
            byte_vld_q <= 1'b1;
          end else begin
            frame_err_q <= 1'b1;
          end
        end else begin
          sr_q      <= {dat_s2_q, sr_q[9:1]};
          bit_cnt_q <= bit_cnt_q + 4'd1;
        end
      end else if (idle_q == IW'(TIMEOUT)) begin
        bit_cnt_q <= '0;
      end else begin
        idle_q <= idle_q + 1'b1;
      end
    end
  end

  // Bit index is row*5 + col.
  function automatic logic [39:0] key_mask(input logic [7:0] code, input logic ext);
    logic [39:0] mk;
    mk = '0;
    if (ext) begin
      case (code)
        8'h14: mk[36] = 1'b1;
        8'h6B: begin mk[0] = 1'b1; mk[19] = 1'b1; end
        8'h72: begin mk[0] = 1'b1; mk[24] = 1'b1; end
        8'h75: begin mk[0] = 1'b1; mk[23] = 1'b1; end
        8'h74: begin mk[0] = 1'b1; mk[22] = 1'b1; end
        default: mk = '0;
      endcase
    end else begin
      case (code)
        8'h12, 8'h59: mk[0] = 1'b1;
        8'h1A: mk[1]  = 1'b1;
        8'h22: mk[2]  = 1'b1;
        8'h21: mk[3]  = 1'b1;
        8'h2A: mk[4]  = 1'b1;
        8'h1C: mk[5]  = 1'b1;
        8'h1B: mk[6]  = 1'b1;
        8'h23: mk[7]  = 1'b1;
        8'h2B: mk[8]  = 1'b1;
        8'h34: mk[9]  = 1'b1;
        8'h15: mk[10] = 1'b1;
        8'h1D: mk[11] = 1'b1;
        8'h24: mk[12] = 1'b1;
        8'h2D: mk[13] = 1'b1;
        8'h2C: mk[14] = 1'b1;
        8'h16: mk[15] = 1'b1;
        8'h1E: mk[16] = 1'b1;
        8'h26: mk[17] = 1'b1;
        8'h25: mk[18] = 1'b1;
        8'h2E: mk[19] = 1'b1;
        8'h45: mk[20] = 1'b1;
        8'h46: mk[21] = 1'b1;
        8'h3E: mk[22] = 1'b1;
        8'h3D: mk[23] = 1'b1;
        8'h36: mk[24] = 1'b1;
        8'h4D: mk[25] = 1'b1;
        8'h44: mk[26] = 1'b1;
        8'h43: mk[27] = 1'b1;
        8'h3C: mk[28] = 1'b1;
        8'h35: mk[29] = 1'b1;
        8'h5A: mk[30] = 1'b1;
        8'h4B: mk[31] = 1'b1;
        8'h42: mk[32] = 1'b1;
        8'h3B: mk[33] = 1'b1;
        8'h33: mk[34] = 1'b1;
        8'h29: mk[35] = 1'b1;
        8'h14: mk[36] = 1'b1;
        8'h3A: mk[37] = 1'b1;
        8'h31: mk[38] = 1'b1;
        8'h32: mk[39] = 1'b1;
        8'h66: begin mk[0] = 1'b1; mk[20] = 1'b1; end
        default: mk = '0;
      endcase
    end
    return mk;
  endfunction

  always_ff @(posedge clk14 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      m_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
    end
  end

  always_comb begin
    logic [39:0] mask;
    logic        ext, brk;
    state_d = state_q;
    m_d     = m_q;
    ext     = (state_q == ST_EXT) || (state_q == ST_EXTBRK);
    brk     = (state_q == ST_BRK) || (state_q == ST_EXTBRK);
    mask    = key_mask(byte_q, ext);
    if (byte_vld_q) begin
      if (byte_q == 8'hAA || byte_q == 8'h00 || byte_q == 8'hFF) begin
        m_d     = '0;
        state_d = ST_IDLE;
      end else if (byte_q == 8'hE0 && state_q == ST_IDLE) begin
        state_d = ST_EXT;
      end else if (byte_q == 8'hF0 && state_q == ST_IDLE) begin
        state_d = ST_BRK;
      end else if (byte_q == 8'hF0 && state_q == ST_EXT) begin
        state_d = ST_EXTBRK;
      end else begin
        m_d     = brk ? (m_q & ~mask) : (m_q | mask);
        state_d = ST_IDLE;
      end
    end
  end

  always_comb begin
    logic [4:0] hit;
    hit = '0;
    for (int r = 0; r < 8; r++) begin
      hit = hit | (m_q[r*5 +: 5] & {5{~addr_hi[r]}});
    end
    kd = ~hit;
  end

endmodule

// File: tb/tb_ps2_keymatrix.sv
// Directed bench for ps2_keymatrix: PS/2 frames in, kd row reads checked from a scoreboard queue.
module tb_ps2_keymatrix;

  logic       clk14 = 1'b0;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] addr_hi;
  logic [4:0] kd;
  logic       frame_err;

  int checks   = 0;
  int failures = 0;
  int err_cnt  = 0;

  typedef struct {
    string      tag;
    logic [7:0] addr;
    logic [4:0] exp;
  } kd_exp_t;

  kd_exp_t sb[$];

  ps2_keymatrix dut (
    .clk14    (clk14),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_dat  (ps2_dat),
    .addr_hi  (addr_hi),
    .kd       (kd),
    .frame_err(frame_err)
  );

  always #5 clk14 = ~clk14;

  always @(posedge clk14) begin
    if (rst_n && frame_err) err_cnt++;
  end

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad_par);
    return {1'b1, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk14);
      ps2_dat = bits[i];
      repeat (10) @(negedge clk14);
      ps2_clk = 1'b0;
      repeat (20) @(negedge clk14);
      ps2_clk = 1'b1;
      repeat (10) @(negedge clk14);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par = 1'b0);
    send_bits(mk_frame(b, bad_par), 11);
    ps2_dat = 1'b1;
    repeat (20) @(negedge clk14);
  endtask

  task automatic exp_kd(input string tag, input logic [7:0] addr, input logic [4:0] exp);
    kd_exp_t e;
    e.tag  = tag;
    e.addr = addr;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    kd_exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk14);
      addr_hi = e.addr;
      #1;
      checks++;
      assert (kd === e.exp) else begin
        failures++;
        $error("FAIL %s addr=%h kd=%b expected %b", e.tag, e.addr, kd, e.exp);
      end
    end
  endtask

  task automatic chk_err(input string tag, input int exp);
    checks++;
    assert (err_cnt === exp) else begin
      failures++;
      $error("FAIL %s frame_err pulses=%0d expected %0d", tag, err_cnt, exp);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    addr_hi = 8'hFF;
    repeat (5) @(negedge clk14);
    rst_n = 1'b1;
    repeat (5) @(negedge clk14);

    exp_kd("reset_all_rows", 8'h00, 5'b11111);
    drain();
    checks++;
    assert (frame_err === 1'b0) else begin
      failures++;
      $error("FAIL reset_frame_err frame_err=%b expected 0", frame_err);
    end

    send_byte(8'h1C);
    exp_kd("make_A_row1", 8'hFD, 5'b11110);
    exp_kd("make_A_row0", 8'hFE, 5'b11111);
    drain();
    send_byte(8'hF0); send_byte(8'h1C);
    exp_kd("break_A", 8'h00, 5'b11111);
    drain();

    send_byte(8'h12); send_byte(8'h1A);
    exp_kd("cs_z_all_rows", 8'h00, 5'b11100);
    drain();
    send_byte(8'hF0); send_byte(8'h12);
    exp_kd("break_cs", 8'h00, 5'b11101);
    drain();
    send_byte(8'hF0); send_byte(8'h1A);

    send_byte(8'hE0); send_byte(8'h75);
    exp_kd("up_row0", 8'hFE, 5'b11110);
    exp_kd("up_row4", 8'hEF, 5'b10111);
    drain();
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    exp_kd("up_rel_row0", 8'hFE, 5'b11111);
    exp_kd("up_rel_row4", 8'hEF, 5'b11111);
    drain();

    send_byte(8'hE0); send_byte(8'h14);
    exp_kd("ext_ss_row7", 8'h7F, 5'b11101);
    drain();
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h14);

    send_byte(8'h66);
    exp_kd("bksp_row0", 8'hFE, 5'b11110);
    exp_kd("bksp_row4", 8'hEF, 5'b11110);
    drain();
    send_byte(8'hF0); send_byte(8'h66);

    send_byte(8'h0D);
    exp_kd("unmapped", 8'h00, 5'b11111);
    drain();

    send_byte(8'h1C, 1'b1);
    chk_err("parity_err_pulse", 1);
    exp_kd("parity_dropped", 8'h00, 5'b11111);
    drain();
    send_byte(8'h1C);
    chk_err("good_after_parity", 1);
    exp_kd("good_after_parity", 8'hFD, 5'b11110);
    drain();
    send_byte(8'hF0); send_byte(8'h1C);

    send_bits(mk_frame(8'h45, 1'b0), 5);
    ps2_dat = 1'b1;
    repeat (3000) @(negedge clk14);
    send_byte(8'h29);
    chk_err("timeout_no_err", 1);
    exp_kd("timeout_space", 8'h7F, 5'b11110);
    exp_kd("timeout_no_0", 8'hEF, 5'b11111);
    drain();
    send_byte(8'hF0); send_byte(8'h29);

    send_byte(8'h15); send_byte(8'h45); send_byte(8'h5A); send_byte(8'h3A);
    exp_kd("held_keys", 8'h00, 5'b11010);
    drain();
    send_byte(8'hAA);
    exp_kd("bat_clear", 8'h00, 5'b11111);
    drain();

    send_byte(8'h16);
    exp_kd("pre_reset_key", 8'hF7, 5'b11110);
    drain();
    send_byte(8'hF0);
    send_bits(mk_frame(8'h1C, 1'b0), 4);
    ps2_dat = 1'b1;
    #3 rst_n = 1'b0;
    exp_kd("in_reset", 8'h00, 5'b11111);
    drain();
    repeat (5) @(negedge clk14);
    rst_n = 1'b1;
    repeat (5) @(negedge clk14);
    send_byte(8'h1C);
    exp_kd("post_reset_make", 8'hFD, 5'b11110);
    exp_kd("post_reset_no_1", 8'hF7, 5'b11111);
    drain();
    chk_err("final_err_count", 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
